cassette_in: RTL and testbench

// Receive side of the Apple speaker/cassette audio path: converts a 16-bit PCM line-in stream into the Apple cassette-input bit.

---
 rtl/cassette_pkg.sv | 24 ++
 rtl/cassette_dc_block.sv | 60 ++++++
 rtl/cassette_in.sv | 194 +++++++++++++++++++
 tb/tb_cassette_in.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cassette_pkg.sv
// Shared types and constants for the cassette-input receive path.
package cassette_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } cass_state_t;

    localparam logic [15:0] CASS_ADDR_A = 16'hC060;
    localparam logic [15:0] CASS_ADDR_B = 16'hC068;

    // Clamp the 18-bit filter accumulator into signed 16-bit range
    function automatic logic signed [15:0] saturate16(input logic signed [17:0] v);
        if (v > 18'sd32767) begin
            return 16'sh7FFF;
        end else if (v < -18'sd32768) begin
            return 16'sh8000;
        end else begin
            return v[15:0];
        end
    endfunction

endpackage

// File: rtl/cassette_dc_block.sv
// DC-blocking high-pass filter with 16-bit output saturation.
// y = x - x_prev + y_prev - (y_prev >>> DC_SHIFT); result valid one clock
// after an accepted input strobe. Strobes closer than 3 clocks are dropped.
module cassette_dc_block
    import cassette_pkg::*;
#(
    parameter int DC_SHIFT = 6
) (
    input  logic               clk_logic,
    input  logic               system_reset_n,
    input  logic               in_valid_i,
    input  logic signed [15:0] in_sample_i,
    output logic               out_valid_o,
    output logic signed [15:0] out_y_o
);

    logic signed [15:0] x_prev_q, x_prev_d;
    logic signed [15:0] y_q, y_d;
    logic signed [15:0] y_shr;
    logic signed [17:0] acc;
    logic               valid_q, valid_d;
    logic [1:0]         hold_q, hold_d;
    logic               accept;

    // Filter step, plus a short hold-off that enforces the minimum strobe spacing
    always_comb begin
        accept   = in_valid_i && (hold_q == 2'd0);
        y_shr    = y_q >>> DC_SHIFT;
        acc      = {{2{in_sample_i[15]}}, in_sample_i} - {{2{x_prev_q[15]}}, x_prev_q}
                 + {{2{y_q[15]}}, y_q} - {{2{y_shr[15]}}, y_shr};
        x_prev_d = x_prev_q;
        y_d      = y_q;
        valid_d  = accept;
        hold_d   = (hold_q != 2'd0) ? hold_q - 2'd1 : 2'd0;
        if (accept) begin
            x_prev_d = in_sample_i;
            y_d      = saturate16(acc);
            hold_d   = 2'd2;
        end
    end

    // Filter state registers
    always_ff @(posedge clk_logic or negedge system_reset_n) begin
        if (!system_reset_n) begin
            x_prev_q <= '0;
            y_q      <= '0;
            valid_q  <= 1'b0;
            hold_q   <= 2'd0;
        end else begin
            x_prev_q <= x_prev_d;
            y_q      <= y_d;
            valid_q  <= valid_d;
            hold_q   <= hold_d;
        end
    end

    assign out_valid_o = valid_q;
    assign out_y_o     = y_q;

endmodule

// File: rtl/cassette_in.sv
// Apple cassette-input receiver: PCM line-in -> DC block -> hysteresis
// comparator with carrier squelch -> cassette bit on D7 for $C060/$C068 reads.
// Optional leader-tone detector enabled by defining CASSETTE_TONE_DETECT_EN.
module cassette_in
    import cassette_pkg::*;
#(
    parameter int ENABLE          = 1,
    parameter int HYST            = 1024,
    parameter int DC_SHIFT        = 6,
    parameter int SILENCE_SAMPLES = 2048
`ifdef CASSETTE_TONE_DETECT_EN
    ,
    parameter int TONE_MIN        = 25,
    parameter int TONE_MAX        = 32,
    parameter int TONE_COUNT      = 32
`endif
) (
    input  logic               clk_logic,
    input  logic               system_reset_n,
    input  logic               sample_valid_i,
    input  logic signed [15:0] sample_i,
    input  logic               phi1_posedge_i,
    input  logic               phi1_negedge_i,
    input  logic [15:0]        addr_i,
    input  logic               rw_n_i,
    input  logic               m2sel_n_i,
    output logic [7:0]         data_o,
    output logic               rd_en_o,
    output logic               cass_bit_o,
    output logic               carrier_o,
    output logic [7:0]         half_period_o,
    output logic               tone_o
);

    localparam logic              EN        = (ENABLE != 0);
    localparam logic signed [15:0] HYST_P   = 16'(HYST);
    localparam logic signed [15:0] HYST_N   = 16'(-HYST);
    localparam logic signed [15:0] QUIET_P  = 16'(HYST / 2);
    localparam logic signed [15:0] QUIET_N  = 16'(-(HYST / 2));
    localparam int                QW        = $clog2(SILENCE_SAMPLES + 1);
    localparam logic [QW-1:0]     SILENCE_C = QW'(SILENCE_SAMPLES);

    logic               y_vld;
    logic signed [15:0] y;

    cassette_dc_block #(.DC_SHIFT(DC_SHIFT)) u_dc_block (
        .clk_logic      (clk_logic),
        .system_reset_n (system_reset_n),
        .in_valid_i     (sample_valid_i),
        .in_sample_i    (sample_i),
        .out_valid_o    (y_vld),
        .out_y_o        (y)
    );

    cass_state_t   state_q, state_d;
    logic [QW-1:0] quiet_q, quiet_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [7:0]    half_q, half_d;
    logic          rd_en_q, rd_en_d;
    logic [7:0]    data_q, data_d;
    logic          above, below, quiet, squelch, trans, match;

    assign above   = (y > HYST_P);
    assign below   = (y < HYST_N);
    assign quiet   = (y > QUIET_N) && (y < QUIET_P);
    // Squelch looks at the count before this sample, so it beats a crossing
    assign squelch = (quiet_q == SILENCE_C);

    // Comparator FSM next state, stepped once per filtered sample
    always_comb begin
        state_d = state_q;
        if (y_vld) begin
            if (squelch) begin
                state_d = IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (above)      state_d = HIGH;
                        else if (below) state_d = LOW;
                    end
                    HIGH:    if (below) state_d = LOW;
                    LOW:     if (above) state_d = HIGH;
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    // Quiet run length and half-period measurement
    always_comb begin
        quiet_d = quiet_q;
        cnt_d   = cnt_q;
        half_d  = half_q;
        trans   = y_vld && (state_q != IDLE) && (state_d != IDLE) && (state_d != state_q);
        if (y_vld) begin
            if (!quiet)        quiet_d = '0;
            else if (!squelch) quiet_d = quiet_q + QW'(1);
            if (trans) begin
                half_d = cnt_q;
                cnt_d  = 8'd1;
            end else if ((state_q == IDLE) && (state_d != IDLE)) begin
                // leaving IDLE restarts the count but is not a measured half period
                cnt_d = 8'd1;
            end else if (cnt_q != 8'hFF) begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    // Bus responder: latch a read of the cassette port at start of Phi0, drop at its end
    always_comb begin
        match   = EN && phi1_negedge_i && rw_n_i && !m2sel_n_i &&
                  ((addr_i == CASS_ADDR_A) || (addr_i == CASS_ADDR_B));
        rd_en_d = rd_en_q;
        data_d  = data_q;
        if (phi1_posedge_i) begin
            rd_en_d = 1'b0;
        end else if (match) begin
            rd_en_d = 1'b1;
            data_d  = {cass_bit_o, 7'b0};
        end
    end

    // State, counter and bus registers
    always_ff @(posedge clk_logic or negedge system_reset_n) begin
        if (!system_reset_n) begin
            state_q <= IDLE;
            quiet_q <= '0;
            cnt_q   <= '0;
            half_q  <= '0;
            rd_en_q <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            quiet_q <= quiet_d;
            cnt_q   <= cnt_d;
            half_q  <= half_d;
            rd_en_q <= rd_en_d;
            data_q  <= data_d;
        end
    end

    assign cass_bit_o    = EN & (state_q == HIGH);
    assign carrier_o     = EN & (state_q != IDLE);
    assign rd_en_o       = EN & rd_en_q;
    assign data_o        = data_q;
    assign half_period_o = half_q;

`ifdef CASSETTE_TONE_DETECT_EN
    localparam int            RW     = $clog2(TONE_COUNT + 1);
    localparam logic [RW-1:0] TONE_C = RW'(TONE_COUNT);

    logic [RW-1:0] run_q, run_d;
    logic          tone_q, tone_d;
    logic          in_win;

    // The half period being latched this transition is cnt_q
    assign in_win = (cnt_q >= 8'(TONE_MIN)) && (cnt_q <= 8'(TONE_MAX));

    // Leader detect: count consecutive in-window half periods, saturating at TONE_COUNT
    always_comb begin
        run_d  = run_q;
        tone_d = tone_q;
        if (state_d == IDLE) begin
            run_d  = '0;
            tone_d = 1'b0;
        end else if (trans) begin
            if (!in_win) begin
                run_d  = '0;
                tone_d = 1'b0;
            end else if (run_q != TONE_C) begin
                run_d = run_q + RW'(1);
                if (run_q + RW'(1) == TONE_C) tone_d = 1'b1;
            end
        end
    end

    // Leader detect registers
    always_ff @(posedge clk_logic or negedge system_reset_n) begin
        if (!system_reset_n) begin
            run_q  <= '0;
            tone_q <= 1'b0;
        end else begin
            run_q  <= run_d;
            tone_q <= tone_d;
        end
    end

    assign tone_o = EN & tone_q;
`else
    assign tone_o = 1'b0;
`endif

endmodule

// File: tb/tb_cassette_in.sv
// Scoreboard bench for cassette_in: stimulus pushes expected output events,
// a negedge monitor pops and compares whenever the outputs change.
module tb_cassette_in;

    logic        clk_logic = 1'b0;
    logic        system_reset_n = 1'b0;
    logic        sample_valid_i = 1'b0;
    logic [15:0] sample_i = '0;
    logic        phi1_posedge_i = 1'b0;
    logic        phi1_negedge_i = 1'b0;
    logic [15:0] addr_i = '0;
    logic        rw_n_i = 1'b1;
    logic        m2sel_n_i = 1'b1;
    logic [7:0]  data_o;
    logic        rd_en_o;
    logic        cass_bit_o;
    logic        carrier_o;
    logic [7:0]  half_period_o;
    logic        tone_o;

    cassette_in dut (
        .clk_logic      (clk_logic),
        .system_reset_n (system_reset_n),
        .sample_valid_i (sample_valid_i),
        .sample_i       (sample_i),
        .phi1_posedge_i (phi1_posedge_i),
        .phi1_negedge_i (phi1_negedge_i),
        .addr_i         (addr_i),
        .rw_n_i         (rw_n_i),
        .m2sel_n_i      (m2sel_n_i),
        .data_o         (data_o),
        .rd_en_o        (rd_en_o),
        .cass_bit_o     (cass_bit_o),
        .carrier_o      (carrier_o),
        .half_period_o  (half_period_o),
        .tone_o         (tone_o)
    );

    always #9 clk_logic = ~clk_logic;

    typedef struct packed {
        logic       bit_v;
        logic       carrier;
        logic       tone;
        logic [7:0] hp;
    } ev_t;

    localparam logic [15:0] P8K  = 16'(8000);
    localparam logic [15:0] N8K  = 16'(-8000);
    localparam logic [15:0] P10K = 16'(10000);

    ev_t        ev_q[$];
    logic [7:0] bus_q[$];
    int         n_chk = 0;
    int         n_fail = 0;
    int         noise[8] = '{240, -160, 360, -400, 80, -280, 400, -240};

    function automatic ev_t mk_ev(input logic b, input logic c, input logic t, input logic [7:0] hp);
        ev_t e;
        e.bit_v = b; e.carrier = c; e.tone = t; e.hp = hp;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        system_reset_n = 1'b0;
        repeat (2) @(posedge clk_logic);
        #1 system_reset_n = 1'b1;
    endtask

    // One sample strobe, then idle so strobes are 3 clocks apart
    task automatic send(input logic [15:0] v);
        @(posedge clk_logic); #1;
        sample_valid_i = 1'b1;
        sample_i       = v;
        @(posedge clk_logic); #1;
        sample_valid_i = 1'b0;
        repeat (2) @(posedge clk_logic);
    endtask

    task automatic send_n(input logic [15:0] v, input int n);
        for (int i = 0; i < n; i++) send(v);
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while ((ev_q.size() != 0 || bus_q.size() != 0) && k < 40) begin
            @(posedge clk_logic);
            k++;
        end
        check({name, "_pending"}, 32'(ev_q.size() + bus_q.size()), 32'd0);
        ev_q.delete();
        bus_q.delete();
    endtask

    task automatic bus_cycle(input logic [15:0] a, input logic rw, input logic m2,
                             input logic exp_rd, input logic [7:0] exp_d);
        @(posedge clk_logic); #1;
        addr_i = a; rw_n_i = rw; m2sel_n_i = m2; phi1_negedge_i = 1'b1;
        if (exp_rd) bus_q.push_back(exp_d);
        @(posedge clk_logic); #1;
        phi1_negedge_i = 1'b0;
        check("rd_en_phi0_start", 32'(rd_en_o), 32'(exp_rd));
        repeat (8) @(posedge clk_logic); #1;
        check("rd_en_phi0_mid", 32'(rd_en_o), 32'(exp_rd));
        phi1_posedge_i = 1'b1;
        @(posedge clk_logic); #1;
        phi1_posedge_i = 1'b0;
        check("rd_en_phi0_end", 32'(rd_en_o), 32'd0);
        addr_i = '0; rw_n_i = 1'b1; m2sel_n_i = 1'b1;
    endtask

    // Monitor: every change of {bit, carrier, tone} must match the next expected event;
    // every rising rd_en must match the next expected read with stable data
    initial begin : monitor
        ev_t        cur, prev_ev, exp_ev;
        logic       prev_rd;
        logic [7:0] held;
        prev_ev = '0; prev_rd = 1'b0; held = '0;
        forever begin
            @(negedge clk_logic);
            cur = mk_ev(cass_bit_o, carrier_o, tone_o, half_period_o);
            if (!system_reset_n) begin
                prev_ev = '0;
                prev_rd = 1'b0;
            end else begin
                if (cur != prev_ev) begin
                    if (ev_q.size() == 0) begin
                        check("event_unexpected", 32'(cur), 32'(prev_ev));
                    end else begin
                        exp_ev = ev_q.pop_front();
                        check("event", 32'(cur), 32'(exp_ev));
                    end
                end
                if (rd_en_o && !prev_rd) begin
                    if (bus_q.size() == 0) check("rd_en_unexpected", 32'(rd_en_o), 32'd0);
                    else                   check("bus_data", 32'(data_o), 32'(bus_q.pop_front()));
                    held = data_o;
                end else if (rd_en_o) begin
                    check("bus_data_hold", 32'(data_o), 32'(held));
                end
                prev_ev = cur;
                prev_rd = rd_en_o;
            end
        end
    end

    initial begin : watchdog
        repeat (90000) @(posedge clk_logic);
        $display("FAIL watchdog: cycle budget exhausted, expected test completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        // 1. reset state, idle, and asynchronous reset during a read
        #1;
        check("rst_rd_en",   32'(rd_en_o),       32'd0);
        check("rst_data",    32'(data_o),        32'd0);
        check("rst_bit",     32'(cass_bit_o),    32'd0);
        check("rst_carrier", 32'(carrier_o),     32'd0);
        check("rst_hp",      32'(half_period_o), 32'd0);
        check("rst_tone",    32'(tone_o),        32'd0);
        do_reset();
        repeat (5) @(posedge clk_logic); #1;
        check("idle_bit",     32'(cass_bit_o), 32'd0);
        check("idle_carrier", 32'(carrier_o),  32'd0);
        check("idle_rd_en",   32'(rd_en_o),    32'd0);
        ev_q.push_back(mk_ev(1'b1, 1'b1, 1'b0, 8'd0));
        send_n(P8K, 3);
        drain("t1_rise");
        @(posedge clk_logic); #1;
        addr_i = 16'hC060; rw_n_i = 1'b1; m2sel_n_i = 1'b0; phi1_negedge_i = 1'b1;
        bus_q.push_back(8'h80);
        @(posedge clk_logic); #1;
        phi1_negedge_i = 1'b0;
        check("mid_rd_en_before", 32'(rd_en_o), 32'd1);
        @(negedge clk_logic); #2;
        system_reset_n = 1'b0;
        #1;
        check("mid_rst_rd_en",   32'(rd_en_o),    32'd0);
        check("mid_rst_bit",     32'(cass_bit_o), 32'd0);
        check("mid_rst_carrier", 32'(carrier_o),  32'd0);
        addr_i = '0; m2sel_n_i = 1'b1;
        drain("t1_bus");
        do_reset();

        // 2. +/-8000 square, 22-sample half periods; ends on a rising edge
        ev_q.push_back(mk_ev(1'b1, 1'b1, 1'b0, 8'd0));
        for (int h = 0; h < 6; h++) begin
            if (h > 0) ev_q.push_back(mk_ev(h % 2 == 0, 1'b1, 1'b0, 8'd22));
            send_n((h % 2 == 0) ? P8K : N8K, 22);
        end
        ev_q.push_back(mk_ev(1'b1, 1'b1, 1'b0, 8'd22));
        send(P8K);
        drain("t2_square");
        check("sq_half_period", 32'(half_period_o), 32'd22);
        check("sq_carrier",     32'(carrier_o),     32'd1);

        // 3. low-level noise: no toggles, then squelch to IDLE
        for (int i = 0; i < 1000; i++) send(16'(noise[i % 8]));
        drain("t3_noise_early");
        check("noise_carrier_held", 32'(carrier_o), 32'd1);
        ev_q.push_back(mk_ev(1'b0, 1'b0, 1'b0, 8'd22));
        for (int i = 0; i < 1600; i++) send(16'(noise[i % 8]));
        drain("t3_squelch");
        check("squelch_carrier", 32'(carrier_o),  32'd0);
        check("squelch_bit",     32'(cass_bit_o), 32'd0);

        // 4. constant step: one rise, decay, squelch, no stuck HIGH
        do_reset();
        ev_q.push_back(mk_ev(1'b1, 1'b1, 1'b0, 8'd0));
        ev_q.push_back(mk_ev(1'b0, 1'b0, 1'b0, 8'd0));
        send_n(P10K, 2500);
        drain("t4_step");
        check("step_carrier", 32'(carrier_o),  32'd0);
        check("step_bit",     32'(cass_bit_o), 32'd0);

        // 5. bus reads
        do_reset();
        ev_q.push_back(mk_ev(1'b1, 1'b1, 1'b0, 8'd0));
        send_n(P8K, 4);
        drain("t5_rise");
        bus_cycle(16'hC060, 1'b1, 1'b0, 1'b1, 8'h80);
        bus_cycle(16'hC068, 1'b1, 1'b0, 1'b1, 8'h80);
        bus_cycle(16'hC061, 1'b1, 1'b0, 1'b0, 8'h00);
        bus_cycle(16'hC060, 1'b0, 1'b0, 1'b0, 8'h00);
        bus_cycle(16'hC068, 1'b1, 1'b1, 1'b0, 8'h00);
        @(posedge clk_logic); #1;
        addr_i = 16'hC060; rw_n_i = 1'b1; m2sel_n_i = 1'b0;
        phi1_negedge_i = 1'b1; phi1_posedge_i = 1'b1;
        @(posedge clk_logic); #1;
        phi1_negedge_i = 1'b0; phi1_posedge_i = 1'b0;
        check("clear_wins", 32'(rd_en_o), 32'd0);
        addr_i = '0; m2sel_n_i = 1'b1;
        drain("t5_bus");
        do_reset();
        bus_cycle(16'hC068, 1'b1, 1'b0, 1'b1, 8'h00);
        drain("t5_bus_zero");

`ifdef CASSETTE_TONE_DETECT_EN
        // 6. 770 Hz leader: tone at 32nd in-window half period, cleared by a long half
        do_reset();
        ev_q.push_back(mk_ev(1'b1, 1'b1, 1'b0, 8'd0));
        for (int h = 0; h < 40; h++) begin
            if (h > 0) ev_q.push_back(mk_ev(h % 2 == 0, 1'b1, h >= 32, 8'd29));
            send_n((h % 2 == 0) ? P8K : N8K, 29);
        end
        ev_q.push_back(mk_ev(1'b1, 1'b1, 1'b1, 8'd29));
        send_n(P8K, 60);
        ev_q.push_back(mk_ev(1'b0, 1'b1, 1'b0, 8'd60));
        send(N8K);
        drain("t6_tone");
        check("tone_cleared", 32'(tone_o), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
